// File: rtl/fan_pwm_monitor.sv
// fan_pwm_monitor
// Receiving end of the fan-motor PWM line. The asynchronous PWM is synchronized,
// edge-detected and timed against a prescaled tick; each accepted rise-to-rise
// period reports its high time, its length and a 2-bit level decoded from the duty.
// A line that stops toggling is reported as stuck, with the level taken from the
// static line state (high -> 3, low -> 0).
module fan_pwm_monitor #(
  parameter int SAMPLE_DIV = 100,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 50000,
  parameter int MIN_PERIOD = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pwm,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_period_cnt,
  output logic [1:0]       o_level,
  output logic             o_valid,
  output logic             o_update,
  output logic             o_stuck
);

  // Prescaler geometry; a divide of 1 still gets a 1-bit counter that never moves.
  localparam int               PRE_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SAMPLE_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);

  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MIN_PER_C    = CNT_W'(MIN_PERIOD);

  // Measurement FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == CNT_MAX) begin
      sat_inc = value;
    end else begin
      sat_inc = value + CNT_ONE;
    end
  endfunction

  // Duty-to-level decode, done in CNT_W+2 bits so 4*H and 3*P cannot overflow.
  function automatic logic [1:0] decode_level(input logic [CNT_W-1:0] high,
                                              input logic [CNT_W-1:0] period);
    logic [CNT_W+1:0] h4;
    logic [CNT_W+1:0] p1;
    logic [CNT_W+1:0] p2;
    logic [CNT_W+1:0] p3;
    h4 = {high, 2'b00};
    p1 = {2'b00, period};
    p2 = {1'b0, period, 1'b0};
    p3 = p2 + p1;
    if (h4 >= p3) begin
      decode_level = 2'd3;
    end else if (h4 >= p2) begin
      decode_level = 2'd2;
    end else if (h4 >= p1) begin
      decode_level = 2'd1;
    end else begin
      decode_level = 2'd0;
    end
  endfunction

  logic             sync1_r;
  logic             sync2_r;
  logic             sync3_r;
  logic             rise_r;
  logic             fall_r;
  logic             edge_s;
  logic [PRE_W-1:0] pre_r;
  logic             tick_s;
  logic [CNT_W-1:0] idle_r;
  logic [CNT_W-1:0] idle_nxt_s;
  logic             stuck_evt_s;
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] high_r;
  logic [CNT_W-1:0] high_nxt_s;
  logic [CNT_W-1:0] per_r;
  logic [CNT_W-1:0] per_nxt_s;
  logic             close_s;
  logic [CNT_W-1:0] close_per_s;
  logic             accept_s;
  logic             pend_r;

  // Two-flop synchronizer plus one delay stage for the edge detector.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= i_pwm;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Any change of the synchronized line; clears the idle timer the same cycle it is detected.
  assign edge_s = sync2_r ^ sync3_r;

  // Registered rise/fall strobes, valid three clocks after the pin edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= sync2_r & ~sync3_r;
      fall_r <= ~sync2_r & sync3_r;
    end
  end

  // Measurement tick: one cycle at the prescaler wrap.
  assign tick_s = (pre_r == PRE_LAST);

  // Prescaler counting 0..SAMPLE_DIV-1.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pre_r <= PRE_ZERO;
    end else if (tick_s) begin
      pre_r <= PRE_ZERO;
    end else begin
      pre_r <= pre_r + PRE_ONE;
    end
  end

  // Idle timer: restarts on every edge, counts ticks, fires once on reaching TIMEOUT, then holds.
  always_comb begin
    idle_nxt_s  = idle_r;
    stuck_evt_s = 1'b0;
    if (edge_s) begin
      idle_nxt_s = CNT_ZERO;
    end else if (tick_s && (idle_r != TIMEOUT_C)) begin
      idle_nxt_s  = idle_r + CNT_ONE;
      stuck_evt_s = (idle_r == TIMEOUT_LAST);
    end else begin
      idle_nxt_s = idle_r;
    end
  end

  // Idle timer register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      idle_r <= CNT_ZERO;
    end else begin
      idle_r <= idle_nxt_s;
    end
  end

  // Period measurement: high/period counting and rise-to-rise period closing.
  always_comb begin
    state_nxt_s = state_r;
    high_nxt_s  = high_r;
    per_nxt_s   = per_r;
    close_s     = 1'b0;
    close_per_s = per_r;
    case (state_r)
      ST_IDLE: begin
        if (rise_r) begin
          state_nxt_s = ST_HIGH;
          high_nxt_s  = CNT_ZERO;
          per_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (tick_s) begin
          high_nxt_s = sat_inc(high_r);
          per_nxt_s  = sat_inc(per_r);
        end else begin
          high_nxt_s = high_r;
          per_nxt_s  = per_r;
        end
        if (fall_r) begin
          state_nxt_s = ST_LOW;
        end else begin
          state_nxt_s = ST_HIGH;
        end
      end
      ST_LOW: begin
        // A tick coinciding with the closing rise belongs to the period being closed.
        if (tick_s) begin
          close_per_s = sat_inc(per_r);
        end else begin
          close_per_s = per_r;
        end
        if (rise_r) begin
          close_s     = 1'b1;
          state_nxt_s = ST_HIGH;
          high_nxt_s  = CNT_ZERO;
          per_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_LOW;
          per_nxt_s   = close_per_s;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        high_nxt_s  = CNT_ZERO;
        per_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Short periods are glitches and are dropped without touching the outputs.
  assign accept_s = close_s && (close_per_s >= MIN_PER_C);

  // FSM and measurement counters; a timeout abandons any period in progress.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
      high_r  <= CNT_ZERO;
      per_r   <= CNT_ZERO;
    end else if (stuck_evt_s) begin
      state_r <= ST_IDLE;
      high_r  <= CNT_ZERO;
      per_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      high_r  <= high_nxt_s;
      per_r   <= per_nxt_s;
    end
  end

  // Result registers: values latch on an accepted close, status and pulse follow one cycle later.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_high_cnt   <= CNT_ZERO;
      o_period_cnt <= CNT_ZERO;
      o_level      <= 2'd0;
      o_valid      <= 1'b0;
      o_update     <= 1'b0;
      o_stuck      <= 1'b0;
      pend_r       <= 1'b0;
    end else if (stuck_evt_s) begin
      o_level  <= sync2_r ? 2'd3 : 2'd0;
      o_valid  <= 1'b0;
      o_update <= 1'b1;
      o_stuck  <= 1'b1;
      pend_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        o_high_cnt   <= high_r;
        o_period_cnt <= close_per_s;
        o_level      <= decode_level(high_r, close_per_s);
        pend_r       <= 1'b1;
      end else begin
        pend_r <= 1'b0;
      end
      if (pend_r) begin
        o_update <= 1'b1;
        o_valid  <= 1'b1;
        o_stuck  <= 1'b0;
      end else begin
        o_update <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fan_pwm_monitor.sv
// Directed bench for fan_pwm_monitor. Three instances share clock and reset:
//  a: SAMPLE_DIV=1, MIN_PERIOD=2, TIMEOUT=200 (main behaviour)
//  g: SAMPLE_DIV=1, MIN_PERIOD=4, TIMEOUT=200 (a 2-tick glitch period is below the minimum)
//  s: SAMPLE_DIV=100, MIN_PERIOD=2, TIMEOUT=200 (prescaled measurement)
// PWM pins change and outputs are sampled on the falling clock edge.
module tb_fan_pwm_monitor;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_a;
  logic             pwm_g;
  logic             pwm_s;
  logic [CNT_W-1:0] a_high, a_per, g_high, g_per, s_high, s_per;
  logic [1:0]       a_level, g_level, s_level;
  logic             a_valid, a_update, a_stuck;
  logic             g_valid, g_update, g_stuck;
  logic             s_valid, s_update, s_stuck;

  int checks = 0;
  int errors = 0;
  int n_upd_a = 0;
  int n_upd_g = 0;
  int n_upd_s = 0;

  fan_pwm_monitor #(.SAMPLE_DIV(1), .CNT_W(CNT_W), .TIMEOUT(200), .MIN_PERIOD(2)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_pwm(pwm_a),
    .o_high_cnt(a_high), .o_period_cnt(a_per), .o_level(a_level),
    .o_valid(a_valid), .o_update(a_update), .o_stuck(a_stuck));

  fan_pwm_monitor #(.SAMPLE_DIV(1), .CNT_W(CNT_W), .TIMEOUT(200), .MIN_PERIOD(4)) dut_g (
    .i_clk(clk), .i_reset(rst), .i_pwm(pwm_g),
    .o_high_cnt(g_high), .o_period_cnt(g_per), .o_level(g_level),
    .o_valid(g_valid), .o_update(g_update), .o_stuck(g_stuck));

  fan_pwm_monitor #(.SAMPLE_DIV(100), .CNT_W(CNT_W), .TIMEOUT(200), .MIN_PERIOD(2)) dut_s (
    .i_clk(clk), .i_reset(rst), .i_pwm(pwm_s),
    .o_high_cnt(s_high), .o_period_cnt(s_per), .o_level(s_level),
    .o_valid(s_valid), .o_update(s_update), .o_stuck(s_stuck));

  always #5 clk = ~clk;

  // Count every clock cycle in which each o_update is high.
  always @(posedge clk) begin
    if (a_update === 1'b1) n_upd_a <= n_upd_a + 1;
    if (g_update === 1'b1) n_upd_g <= n_upd_g + 1;
    if (s_update === 1'b1) n_upd_s <= n_upd_s + 1;
  end

  task automatic hold_a(input logic v, input int n);
    pwm_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_g(input logic v, input int n);
    pwm_g = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_s(input logic v, input int n);
    pwm_s = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    pwm_a = 1'b0;
    pwm_g = 1'b0;
    pwm_s = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int base;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pwm_a = i[1];
      pwm_g = i[2];
      pwm_s = i[0];
      @(negedge clk);
      checks++;
      if ({a_high, a_per, a_level, a_valid, a_update, a_stuck} !== 37'd0 ||
          {g_high, g_per, g_level, g_valid, g_update, g_stuck} !== 37'd0 ||
          {s_high, s_per, s_level, s_valid, s_update, s_stuck} !== 37'd0) begin
        errors++;
        $display("FAIL reset_outputs: cycle %0d a=%h g=%h s=%h, required all 0", i,
                 {a_high, a_per, a_level, a_valid, a_update, a_stuck},
                 {g_high, g_per, g_level, g_valid, g_update, g_stuck},
                 {s_high, s_per, s_level, s_valid, s_update, s_stuck});
      end
    end
    pwm_a = 1'b0;
    pwm_g = 1'b0;
    pwm_s = 1'b0;
    rst   = 1'b0;
    repeat (5) @(negedge clk);
    base = n_upd_a;
    hold_a(1'b1, 25);
    hold_a(1'b0, 75);
    checks++;
    if (n_upd_a - base !== 0) begin
      errors++;
      $display("FAIL first_rise_no_update: updates %0d, required 0", n_upd_a - base);
    end
    hold_a(1'b1, 8);
    checks++;
    if (n_upd_a - base !== 1) begin
      errors++;
      $display("FAIL second_rise_update: updates %0d, required 1", n_upd_a - base);
    end
    checks++;
    if (a_high !== 16'd25 || a_per !== 16'd100) begin
      errors++;
      $display("FAIL second_rise_values: high %0d period %0d, required 25 100", a_high, a_per);
    end
  endtask

  task automatic test_periodic();
    int base;
    do_reset();
    hold_a(1'b0, 5);
    base = n_upd_a;
    repeat (4) begin
      hold_a(1'b1, 25);
      hold_a(1'b0, 75);
    end
    hold_a(1'b1, 8);
    checks++;
    if (n_upd_a - base !== 4) begin
      errors++;
      $display("FAIL periodic_update_count: updates %0d, required 4", n_upd_a - base);
    end
    checks++;
    if (a_high !== 16'd25 || a_per !== 16'd100 || a_level !== 2'd1) begin
      errors++;
      $display("FAIL periodic_values: high %0d period %0d level %0d, required 25 100 1",
               a_high, a_per, a_level);
    end
    checks++;
    if (a_valid !== 1'b1 || a_stuck !== 1'b0) begin
      errors++;
      $display("FAIL periodic_status: valid %b stuck %b, required 1 0", a_valid, a_stuck);
    end
    // Reset in the middle of a low phase clears everything at once.
    hold_a(1'b1, 17);
    hold_a(1'b0, 20);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_high, a_per, a_level, a_valid, a_update, a_stuck} !== 37'd0) begin
      errors++;
      $display("FAIL midperiod_reset: outputs %h, required 0",
               {a_high, a_per, a_level, a_valid, a_update, a_stuck});
    end
    @(negedge clk);
    rst  = 1'b0;
    base = n_upd_a;
    hold_a(1'b0, 30);
    checks++;
    if (n_upd_a - base !== 0 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL partial_not_reported: updates %0d valid %b, required 0 0",
               n_upd_a - base, a_valid);
    end
  endtask

  task automatic test_duty_sweep();
    int         hi_t[6] = '{1, 49, 50, 74, 75, 99};
    logic [1:0] lv_t[6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    for (int k = 0; k < 6; k++) begin
      do_reset();
      hold_a(1'b0, 5);
      hold_a(1'b1, hi_t[k]);
      hold_a(1'b0, 100 - hi_t[k]);
      hold_a(1'b1, 8);
      checks++;
      if (a_level !== lv_t[k]) begin
        errors++;
        $display("FAIL duty_level: high %0d level %0d, required %0d", hi_t[k], a_level, lv_t[k]);
      end
      checks++;
      if (a_high !== 16'(hi_t[k]) || a_per !== 16'd100) begin
        errors++;
        $display("FAIL duty_counts: high %0d period %0d, required %0d 100", a_high, a_per, hi_t[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int base;
    int lat;
    do_reset();
    hold_a(1'b0, 5);
    hold_a(1'b1, 25);
    hold_a(1'b0, 75);
    // Last edge: rise, then the line stays high.
    pwm_a = 1'b1;
    lat   = 0;
    base  = 0;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      if (i == 10) base = n_upd_a;
      if (i > 10 && a_update === 1'b1 && lat == 0) lat = i;
    end
    checks++;
    if (lat !== 203) begin
      errors++;
      $display("FAIL stuck_high_latency: update at cycle %0d, required 203", lat);
    end
    checks++;
    if (n_upd_a - base !== 1) begin
      errors++;
      $display("FAIL stuck_high_pulses: updates %0d, required 1", n_upd_a - base);
    end
    checks++;
    if (a_stuck !== 1'b1 || a_valid !== 1'b0 || a_level !== 2'd3) begin
      errors++;
      $display("FAIL stuck_high_status: stuck %b valid %b level %0d, required 1 0 3",
               a_stuck, a_valid, a_level);
    end
    // Now the line falls and stays low.
    pwm_a = 1'b0;
    lat   = 0;
    base  = n_upd_a;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      if (a_update === 1'b1 && lat == 0) lat = i;
    end
    checks++;
    if (lat !== 203) begin
      errors++;
      $display("FAIL stuck_low_latency: update at cycle %0d, required 203", lat);
    end
    checks++;
    if (n_upd_a - base !== 1) begin
      errors++;
      $display("FAIL stuck_low_pulses: updates %0d, required 1", n_upd_a - base);
    end
    checks++;
    if (a_stuck !== 1'b1 || a_valid !== 1'b0 || a_level !== 2'd0) begin
      errors++;
      $display("FAIL stuck_low_status: stuck %b valid %b level %0d, required 1 0 0",
               a_stuck, a_valid, a_level);
    end
    // Recovery: the first rise only starts a period.
    base = n_upd_a;
    hold_a(1'b1, 25);
    hold_a(1'b0, 75);
    checks++;
    if (n_upd_a - base !== 0 || a_stuck !== 1'b1) begin
      errors++;
      $display("FAIL recover_first_rise: updates %0d stuck %b, required 0 1", n_upd_a - base, a_stuck);
    end
    hold_a(1'b1, 8);
    checks++;
    if (n_upd_a - base !== 1 || a_valid !== 1'b1 || a_stuck !== 1'b0 ||
        a_high !== 16'd25 || a_per !== 16'd100) begin
      errors++;
      $display("FAIL recover_update: updates %0d valid %b stuck %b high %0d period %0d, required 1 1 0 25 100",
               n_upd_a - base, a_valid, a_stuck, a_high, a_per);
    end
  endtask

  task automatic test_glitch();
    int base;
    do_reset();
    hold_g(1'b0, 5);
    repeat (2) begin
      hold_g(1'b1, 25);
      hold_g(1'b0, 75);
    end
    base = n_upd_g;
    // Rise closes a good period, then a 1-low-cycle dip creates a 2-tick period.
    hold_g(1'b1, 1);
    hold_g(1'b0, 1);
    hold_g(1'b1, 30);
    hold_g(1'b0, 70);
    checks++;
    if (n_upd_g - base !== 1) begin
      errors++;
      $display("FAIL glitch_no_update: updates %0d, required 1", n_upd_g - base);
    end
    checks++;
    if (g_high !== 16'd25 || g_per !== 16'd100 || g_level !== 2'd1 || g_valid !== 1'b1) begin
      errors++;
      $display("FAIL glitch_hold: high %0d period %0d level %0d valid %b, required 25 100 1 1",
               g_high, g_per, g_level, g_valid);
    end
    hold_g(1'b1, 8);
    checks++;
    if (n_upd_g - base !== 2 || g_high !== 16'd30 || g_per !== 16'd100 || g_level !== 2'd1) begin
      errors++;
      $display("FAIL glitch_after: updates %0d high %0d period %0d level %0d, required 2 30 100 1",
               n_upd_g - base, g_high, g_per, g_level);
    end
  endtask

  task automatic test_prescaled();
    int base;
    do_reset();
    hold_s(1'b0, 5);
    base = n_upd_s;
    repeat (2) begin
      hold_s(1'b1, 2500);
      hold_s(1'b0, 7500);
    end
    hold_s(1'b1, 10);
    checks++;
    if (n_upd_s - base !== 2) begin
      errors++;
      $display("FAIL prescaled_updates: updates %0d, required 2", n_upd_s - base);
    end
    checks++;
    if (s_high < 16'd24 || s_high > 16'd26 || s_per < 16'd99 || s_per > 16'd101) begin
      errors++;
      $display("FAIL prescaled_counts: high %0d period %0d, required 25+/-1 100+/-1", s_high, s_per);
    end
    checks++;
    if (s_level !== 2'd1 || s_valid !== 1'b1) begin
      errors++;
      $display("FAIL prescaled_level: level %0d valid %b, required 1 1", s_level, s_valid);
    end
  endtask

  initial begin
    rst   = 1'b1;
    pwm_a = 1'b0;
    pwm_g = 1'b0;
    pwm_s = 1'b0;
    @(negedge clk);
    test_reset();
    test_periodic();
    test_duty_sweep();
    test_timeout();
    test_glitch();
    test_prescaled();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
